// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the HI/LO pair.
// Signed ops use magnitudes plus sign flags. A 32-step shift-add or restoring-divide pass is followed by one fix-up cycle.
module muldiv_sequencer #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iReadHiLo,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO,
    output logic             oBusy,
    output logic             oStall,
    output logic             oDone
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               start_md;
    logic               op_is_div;
    logic               op_signed;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        start_md  = iStart & ~iOp[2];
        op_is_div = iOp[1];
        op_signed = ~iOp[0];
        div_zero  = op_is_div & (iB == '0);
        a_mag     = (op_signed & iA[WIDTH-1]) ? -iA : iA;
        b_mag     = (op_signed & iB[WIDTH-1]) ? -iB : iB;
    end

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Divide: acc = {remainder, quotient}. The trial needs WIDTH+1 bits so the shifted-out MSB is kept.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (div_trial[WIDTH]) begin
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        prod = neg_res ? -acc : acc;
        quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_md && !div_zero) state_next = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oBusy  = (state != IDLE);
        oStall = oBusy & (iReadHiLo | (iStart & ~(iOp[2] & iOp[1])));
        oHI    = hi;
        oLO    = lo;
        oDone  = done;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            done    <= 1'b0;
            acc     <= '0;
            operand <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (iOp == 3'b100) begin
                            hi <= iA;
                        end else if (iOp == 3'b101) begin
                            lo <= iA;
                        end else if (!iOp[2]) begin
                            if (div_zero) begin
                                hi   <= iA;
                                lo   <= DIV0_LO;
                                done <= 1'b1;
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, (op_is_div ? a_mag : b_mag)};
                                operand <= op_is_div ? b_mag : a_mag;
                                op_div  <= op_is_div;
                                neg_res <= op_signed & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                                neg_rem <= op_signed & iA[WIDTH-1];
                                count   <= '0;
                            end
                        end
                    end
                end
                RUN: begin
                    acc   <= op_div ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        lo <= quot;
                        hi <= rem;
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer.
// The reference model uses plain 64-bit signed/unsigned arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hilo;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        stall;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH  (32),
        .DIV0_LO(32'hFFFFFFFF)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iStart   (start),
        .iOp      (op),
        .iA       (a),
        .iB       (b),
        .iReadHiLo(rd_hilo),
        .oHI      (hi_o),
        .oLO      (lo_o),
        .oBusy    (busy),
        .oStall   (stall),
        .oDone    (done)
    );

    // Returns {HI, LO} for a mult/div request.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        if (o[1] && y == 32'd0) begin
            res = {x, 32'hFFFFFFFF};
        end else begin
            case (o[1:0])
                2'b00: res = 64'(sx * sy);
                2'b01: res = {32'd0, x} * {32'd0, y};
                2'b10: begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
                default: res = {x % y, x / y};
            endcase
        end
        return res;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Issues a mult/div and follows it to the oDone cycle, checking timing and results against the model.
    task automatic do_muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        logic [63:0] exp;
        logic        rd;
        exp = ref_md(o, x, y);
        issue(o, x, y);
        if (!(o[1] && y == 32'd0)) begin
            for (int i = 0; i < 33; i++) begin
                rd      = 1'($urandom_range(0, 1));
                rd_hilo = rd;
                #1;
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || stall !== rd || hi_o !== m_hi || lo_o !== m_lo) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: busy=%b done=%b stall=%b hi=%h lo=%h, required busy=1 done=0 stall=%b hi=%h lo=%h",
                             name, i, busy, done, stall, hi_o, lo_o, rd, m_hi, m_lo);
                end
                @(posedge clk);
                #1;
            end
            rd_hilo = 1'b0;
        end
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0 || hi_o !== exp[63:32] || lo_o !== exp[31:0]) begin
            errors++;
            $display("FAIL %s result: done=%b busy=%b stall=%b hi=%h lo=%h, required done=1 busy=0 stall=0 hi=%h lo=%h",
                     name, done, busy, stall, hi_o, lo_o, exp[63:32], exp[31:0]);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'b111;
        a       = '0;
        b       = '0;
        rd_hilo = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, required all zero", hi_o, lo_o, busy, done, stall);
        end
        rst     = 1'b0;
        rd_hilo = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
    endtask

    task automatic test_mult;
        do_muldiv(3'b000, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
        checks++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mult_neg3x7 const: hi=%h lo=%h, required ffffffff ffffffeb", hi_o, lo_o);
        end
        do_muldiv(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        checks++;
        if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_max const: hi=%h lo=%h, required fffffffe 00000001", hi_o, lo_o);
        end
        do_muldiv(3'b000, 32'h80000000, 32'h80000000, "mult_minsq");
        checks++;
        if (hi_o !== 32'h40000000 || lo_o !== 32'h00000000) begin
            errors++;
            $display("FAIL mult_minsq const: hi=%h lo=%h, required 40000000 00000000", hi_o, lo_o);
        end
    endtask

    task automatic test_div;
        do_muldiv(3'b010, 32'hFFFFFFF9, 32'd2, "div_neg7by2");
        checks++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg7by2 const: hi=%h lo=%h, required ffffffff fffffffd", hi_o, lo_o);
        end
        do_muldiv(3'b011, 32'd100, 32'd7, "divu_100by7");
        checks++;
        if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
            errors++;
            $display("FAIL divu_100by7 const: hi=%h lo=%h, required 2 14", hi_o, lo_o);
        end
        do_muldiv(3'b010, 32'h80000000, 32'hFFFFFFFF, "div_min_by_neg1");
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'h80000000) begin
            errors++;
            $display("FAIL div_min_by_neg1 const: hi=%h lo=%h, required 0 80000000", hi_o, lo_o);
        end
    endtask

    task automatic test_div_zero;
        @(posedge clk);
        #1;
        do_muldiv(3'b011, 32'd5, 32'd0, "divu_by_zero");
        checks++;
        if (hi_o !== 32'd5 || lo_o !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL divu_by_zero const: hi=%h lo=%h, required 5 ffffffff", hi_o, lo_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL divu_by_zero after: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_stall;
        logic [63:0] exp;
        exp = ref_md(3'b000, 32'd123, 32'hFFFFFE38);
        issue(3'b000, 32'd123, 32'hFFFFFE38);
        rd_hilo = 1'b1;
        start   = 1'b1;
        op      = 3'b101;
        a       = 32'd9;
        #1;
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (stall !== 1'b1 || hi_o !== m_hi || lo_o !== m_lo) begin
                errors++;
                $display("FAIL stall cycle %0d: stall=%b hi=%h lo=%h, required stall=1 hi=%h lo=%h", i, stall, hi_o, lo_o, m_hi, m_lo);
            end
            @(posedge clk);
            #2;
        end
        checks++;
        if (done !== 1'b1 || stall !== 1'b0 || hi_o !== exp[63:32] || lo_o !== exp[31:0]) begin
            errors++;
            $display("FAIL stall done cycle: done=%b stall=%b hi=%h lo=%h, required done=1 stall=0 hi=%h lo=%h",
                     done, stall, hi_o, lo_o, exp[63:32], exp[31:0]);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        rd_hilo = 1'b0;
        checks++;
        if (lo_o !== 32'd9 || hi_o !== exp[63:32] || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall reissue mtlo: lo=%h hi=%h busy=%b, required lo=9 hi=%h busy=0", lo_o, hi_o, busy, exp[63:32]);
        end
        m_hi = exp[63:32];
        m_lo = 32'd9;
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        issue(3'b010, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi_o, lo_o, busy, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid ghost: done or busy seen=1, required 0 after reset");
        end
        m_hi = '0;
        m_lo = '0;
        do_muldiv(3'b000, 32'd2, 32'd3, "mult_after_reset");
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd6) begin
            errors++;
            $display("FAIL mult_after_reset const: hi=%h lo=%h, required 0 6", hi_o, lo_o);
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (!o[2]) begin
                do_muldiv(o, x, y, "random_md");
            end else begin
                issue(o, x, y);
                if (o == 3'b100) m_hi = x;
                if (o == 3'b101) m_lo = x;
                checks++;
                if (hi_o !== m_hi || lo_o !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL random_move op=%0d: hi=%h lo=%h busy=%b done=%b, required hi=%h lo=%h busy=0 done=0",
                             o, hi_o, lo_o, busy, done, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_stall;
        test_reset_mid;
        test_random;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
